// File: rtl/edge_timestamp_fifo.sv
// edge_timestamp_fifo
// Stamps rising/falling edge pulses with a coarse free-running counter and
// queues the resulting records in a small FIFO with a registered head.
//
// Ports
//   iClk       clock, all state changes on the rising edge
//   iRst       synchronous active-high reset
//   enable     run enable for the counter and event capture
//   iRise      one-cycle rising-edge pulse
//   iFall      one-cycle falling-edge pulse
//   oData      head record {edge type (1 = rise), timestamp}
//   oValid     oData holds a valid record
//   iReady     consumer accepts the head record
//   oOverflow  sticky: at least one event was dropped
//   oConflict  sticky: rise and fall seen in the same enabled cycle
//   oDropCnt   saturating count of dropped events
module edge_timestamp_fifo #(
    parameter int COUNT_W = 16,
    parameter int DEPTH   = 8
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               enable,
    input  logic               iRise,
    input  logic               iFall,
    output logic [COUNT_W:0]   oData,
    output logic               oValid,
    input  logic               iReady,
    output logic               oOverflow,
    output logic               oConflict,
    output logic [7:0]         oDropCnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [COUNT_W-1:0] counter_r;
    logic [COUNT_W:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   wrPtr_r;
    logic [PTR_W-1:0]   rdPtr_r;
    logic [PTR_W-1:0]   rdNext_s;
    logic [FILL_W-1:0]  fill_r;
    logic [FILL_W-1:0]  fillNext_s;
    logic               event_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               headFromIn_s;
    logic [COUNT_W:0]   evtRec_s;
    logic [COUNT_W:0]   headNext_s;
    logic [COUNT_W:0]   data_r;
    logic               valid_r;
    logic               overflow_r;
    logic               conflict_r;
    logic [7:0]         dropCnt_r;

    // Event qualification, push/pop decisions and next head record.
    always_comb begin
        event_s      = 1'b0;
        evtRec_s     = '0;
        full_s       = 1'b0;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        rdNext_s     = rdPtr_r;
        fillNext_s   = fill_r;
        headFromIn_s = 1'b0;
        headNext_s   = '0;

        event_s  = enable & (iRise | iFall);
        // Rise wins when both pulses arrive together.
        evtRec_s = {iRise, counter_r};
        full_s   = (fill_r == FILL_W'(DEPTH));
        pop_s    = valid_r & iReady;
        push_s   = event_s & (~full_s | pop_s);
        drop_s   = event_s & full_s & ~pop_s;

        if (pop_s) begin
            rdNext_s = rdPtr_r + PTR_W'(1);
        end else begin
            rdNext_s = rdPtr_r;
        end

        case ({push_s, pop_s})
            2'b10:   fillNext_s = fill_r + FILL_W'(1);
            2'b01:   fillNext_s = fill_r - FILL_W'(1);
            default: fillNext_s = fill_r;
        endcase

        // The incoming record becomes the head only if nothing else remains
        // after this cycle's pop; it is not yet in memory, so take it directly.
        if (pop_s) begin
            headFromIn_s = push_s & (fill_r == FILL_W'(1));
        end else begin
            headFromIn_s = push_s & (fill_r == FILL_W'(0));
        end

        if (headFromIn_s) begin
            headNext_s = evtRec_s;
        end else begin
            headNext_s = mem_r[rdNext_s];
        end
    end

    // Record storage; contents are meaningless until referenced by the fill count.
    always_ff @(posedge iClk) begin
        if (!iRst && push_s) begin
            mem_r[wrPtr_r] <= evtRec_s;
        end
    end

    // Counter, pointers, registered head and status flags.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            counter_r  <= '0;
            wrPtr_r    <= '0;
            rdPtr_r    <= '0;
            fill_r     <= '0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            conflict_r <= 1'b0;
            dropCnt_r  <= 8'd0;
        end else begin
            if (enable) begin
                counter_r <= counter_r + COUNT_W'(1);
            end
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            rdPtr_r <= rdNext_s;
            fill_r  <= fillNext_s;
            valid_r <= (fillNext_s != FILL_W'(0));
            // Head holds its last value once the FIFO runs dry.
            if (fillNext_s != FILL_W'(0)) begin
                data_r <= headNext_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (dropCnt_r != 8'hFF) begin
                    dropCnt_r <= dropCnt_r + 8'd1;
                end
            end
            if (enable && iRise && iFall) begin
                conflict_r <= 1'b1;
            end
        end
    end

    assign oData     = data_r;
    assign oValid    = valid_r;
    assign oOverflow = overflow_r;
    assign oConflict = conflict_r;
    assign oDropCnt  = dropCnt_r;

endmodule
